// File: rtl/detector_tono_pkg.sv
// Shared types and defaults for the tone period detector.
// Holds the FSM state encoding and the default counter width.
package detector_tono_pkg;

    localparam int unsigned CNT_W_DEF = 28;

    typedef enum logic [1:0] {
        SILENT  = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } tono_state_t;

endpackage

// File: rtl/detector_tono_sincronizador.sv
// Brings tone_in into the clock_in domain and flags its rising edges.
// The sync output lags tone_in by two flops; rise is sync & ~hist.
module sincronizador (
    input  logic clock_in,
    input  logic reset,
    input  logic tone_in,
    output logic sync,
    output logic rise
);

    logic       meta;
    logic       hist;
    logic [1:0] fill;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
            fill <= 2'd0;
        end else begin
            meta <= tone_in;
            sync <= meta;
            hist <= sync;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end

    // The pipeline holds reset zeros for three edges after release.
    // Without this qualifier, a level that is already high would look like a rise.
    assign rise = sync & ~hist & (fill == 2'd3);

endmodule

// File: rtl/detector_tono.sv
// Measures the period and high time of a square wave on tone_in, in clock_in cycles.
// It reports silence when no rise is seen within TIMEOUT cycles.
//
// state   | meaning
// SILENT  | no tone; counters held at 0; waiting for a first rise
// ARMED   | one rise seen; waiting for a full period before reporting
// MEASURE | tone present; each accepted rise reports a period
module detector_tono
    import detector_tono_pkg::*;
#(
    parameter int unsigned      CNT_W      = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT    = CNT_W'(50_000_000),
    parameter logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(4)
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             period_valid,
    output logic             silence
);

    localparam logic [CNT_W-1:0] LAST_CNT = TIMEOUT - CNT_W'(1);

    tono_state_t      state;
    tono_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             sync;
    logic             rise;
    logic             accept;
    logic             timeout;
    logic             restart;
    logic             pulse;

    sincronizador u_sincronizador (
        .clock_in (clock_in),
        .reset    (reset),
        .tone_in  (tone_in),
        .sync     (sync),
        .rise     (rise)
    );

    assign cnt_inc = cnt + CNT_W'(1);
    assign accept  = rise & (cnt_inc >= MIN_PERIOD);
    assign timeout = (cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        pulse     = 1'b0;
        case (state)
            SILENT: begin
                if (rise) begin
                    state_nxt = ARMED;
                    restart   = 1'b1;
                end
            end
            ARMED: begin
                if (accept) begin
                    state_nxt = MEASURE;
                    restart   = 1'b1;
                    pulse     = 1'b1;
                end else if (timeout) begin
                    state_nxt = SILENT;
                end
            end
            MEASURE: begin
                if (accept) begin
                    restart = 1'b1;
                    pulse   = 1'b1;
                end else if (timeout) begin
                    state_nxt = SILENT;
                end
            end
            default: state_nxt = SILENT;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state        <= SILENT;
            cnt          <= '0;
            hcnt         <= '0;
            period_out   <= '0;
            high_out     <= '0;
            period_valid <= 1'b0;
            silence      <= 1'b1;
        end else begin
            state        <= state_nxt;
            period_valid <= pulse;
            silence      <= (state_nxt != MEASURE);
            // The rise cycle already has sync=1, so it is the first high cycle of the new period.
            if (restart) begin
                cnt  <= '0;
                hcnt <= CNT_W'(1);
            end else if (state_nxt == SILENT) begin
                cnt  <= '0;
                hcnt <= '0;
            end else begin
                cnt  <= cnt_inc;
                hcnt <= hcnt + CNT_W'(sync);
            end
            if (pulse) begin
                period_out <= cnt_inc;
                high_out   <= hcnt;
            end
        end
    end

endmodule

// File: tb/tb_detector_tono.sv
// Directed bench for detector_tono with TIMEOUT=100 and MIN_PERIOD=4.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled at the same point.
module tb_detector_tono;

    localparam int CNT_W = 28;

    logic             clock_in = 1'b0;
    logic             reset    = 1'b1;
    logic             tone_in  = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_valid;
    logic             silence;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse_cyc = 0;
    int pulse_gap = 0;
    int silent_cyc;
    int p0;
    int c0;
    logic silence_low_seen = 1'b0;

    detector_tono #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (28'd100),
        .MIN_PERIOD (28'd4)
    ) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .tone_in      (tone_in),
        .period_out   (period_out),
        .high_out     (high_out),
        .period_valid (period_valid),
        .silence      (silence)
    );

    always #5 clock_in = ~clock_in;

    task automatic tick();
        @(posedge clock_in);
        #1;
        cyc++;
        if (period_valid) begin
            pulses++;
            pulse_gap      = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
        end
        if (!silence) silence_low_seen = 1'b1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wave(input int hi, input int lo);
        tone_in = 1'b1;
        repeat (hi) tick();
        tone_in = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (3) tick();
        chk("rst_period_out", int'(period_out), 0);
        chk("rst_high_out", int'(high_out), 0);
        chk("rst_valid", int'(period_valid), 0);
        chk("rst_silence", int'(silence), 1);
        reset = 1'b0;
        repeat (5) tick();

        // steady period-10 wave, 5 high
        p0 = pulses;
        wave(5, 5);
        chk("arm_no_pulse", pulses - p0, 0);
        chk("arm_silence", int'(silence), 1);
        c0 = cyc;
        wave(5, 5);
        chk("first_pulse_cnt", pulses - p0, 1);
        chk("first_pulse_lat", last_pulse_cyc - c0, 3);
        chk("first_period", int'(period_out), 10);
        chk("first_high", int'(high_out), 5);
        chk("tone_silence", int'(silence), 0);
        wave(5, 5);
        wave(5, 5);
        chk("steady_pulse_cnt", pulses - p0, 3);
        chk("steady_gap", pulse_gap, 10);

        // wave stops: silence rises 100 edges after the accepting edge
        tone_in = 1'b1;
        repeat (5) tick();
        tone_in = 1'b0;
        silent_cyc = -1;
        for (int i = 0; i < 300 && silent_cyc < 0; i++) begin
            tick();
            if (silence) silent_cyc = cyc;
        end
        chk("timeout_latency", silent_cyc - last_pulse_cyc, 100);
        chk("timeout_hold_period", int'(period_out), 10);
        chk("timeout_hold_high", int'(high_out), 5);

        // boundary: 100-cycle period accepted, 101-cycle gap times out
        p0 = pulses;
        wave(2, 98);
        wave(2, 99);
        chk("p100_pulse", pulses - p0, 1);
        chk("p100_period", int'(period_out), 100);
        chk("p100_high", int'(high_out), 2);
        wave(5, 5);
        chk("p101_no_pulse", pulses - p0, 1);
        chk("p101_silence", int'(silence), 1);
        chk("p101_hold_period", int'(period_out), 100);
        wave(5, 5);
        chk("after101_pulse", pulses - p0, 2);
        chk("after101_period", int'(period_out), 10);
        tone_in = 1'b0;
        repeat (120) tick();
        chk("idle_silence", int'(silence), 1);

        // glitch: a 1-cycle dip makes a second rise 3 cycles after the real one
        p0 = pulses;
        wave(5, 5);
        wave(5, 5);
        tone_in = 1'b1; tick(); tick();
        tone_in = 1'b0; tick();
        tone_in = 1'b1; tick(); tick();
        tone_in = 1'b0; repeat (5) tick();
        chk("glitch_pulse_cnt", pulses - p0, 2);
        chk("glitch_prev_period", int'(period_out), 10);
        wave(5, 5);
        chk("post_glitch_cnt", pulses - p0, 3);
        chk("post_glitch_period", int'(period_out), 10);
        chk("post_glitch_high", int'(high_out), 4);

        // reset in the middle of a period
        tone_in = 1'b1;
        repeat (3) tick();
        p0 = pulses;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("midrst_valid", int'(period_valid), 0);
        chk("midrst_period", int'(period_out), 0);
        chk("midrst_high", int'(high_out), 0);
        chk("midrst_silence", int'(silence), 1);
        tone_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("midrst_no_pulse", pulses - p0, 0);
        wave(5, 5);
        chk("rearm_no_pulse", pulses - p0, 0);
        wave(5, 5);
        chk("rearm_pulse", pulses - p0, 1);
        chk("rearm_period", int'(period_out), 10);

        // tone held high from reset release
        tone_in = 1'b1;
        reset   = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        silence_low_seen = 1'b0;
        p0 = pulses;
        repeat (250) tick();
        chk("stuck_high_no_pulse", pulses - p0, 0);
        chk("stuck_high_silence_seen", int'(silence_low_seen), 0);
        chk("stuck_high_silence", int'(silence), 1);

        // a high level at release must not arm: the next real rise only arms
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        tone_in = 1'b0;
        repeat (5) tick();
        tone_in = 1'b1;
        repeat (10) tick();
        chk("release_high_not_rise", pulses - p0, 0);
        chk("release_high_silence", int'(silence), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
